field_receiver: RTL
===================

# field_receiver

Parametrised successor to the fixed-length byte receiver. It collects a field of up to `L` bytes from a byte stream, in one of two modes selected per field: fixed length, or terminated by a delimiter. It sits after the UART byte strobe in the GPZDA/NMEA sentence path and reports completion, the byte count, the terminator that ended the field, and overflow or short-field errors.

## Interface
- `B`, 8: bits per byte.
- `L`, 10: maximum field length in bytes (1..255).
- `DELIM_A`, 8'h2C (`,`): first field delimiter.
- `DELIM_B`, 8'h2A (`*`): second field delimiter.
- `clock`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  arms a new field, starting at the next cycle; aborts any field in progress.
- `length`  in  CW=$clog2(L+1)  latched at `start`. 0 selects delimited mode; 1..L selects fixed mode; values >L are treated as L.
- `load`  in  1  `data` is valid this cycle.
- `data`  in  B  incoming byte.
- `busy`  out  1  high in RECV and DISCARD.
- `resolve`  out  1  one-cycle pulse: field complete.
- `overflow`  out  1  one-cycle pulse: delimited field exceeded `L` bytes.
- `short`  out  1  one-cycle pulse: delimiter arrived before a fixed-length field was complete.
- `result`  out  L*B  field bytes, right-aligned (last byte in `[B-1:0]`), unused upper bytes zero.
- `count`  out  CW  number of bytes in `result`.
- `term`  out  2  what ended the field: 0 = length reached, 1 = `DELIM_A`, 2 = `DELIM_B`.

## Operation
- States: IDLE, RECV, DISCARD. Reset sets IDLE; all outputs 0.
- `start`, in any state: go to RECV, latch `length`, clear `result` and `count`. `start` has priority; a `load` in the same cycle is ignored.
- IDLE: `load` is ignored.
- RECV, `load` with a delimiter byte (`DELIM_A` or `DELIM_B`):
  - Delimited mode: pulse `resolve`, set `term` to 1 or 2, go IDLE. The delimiter is not stored.
  - An empty field (delimiter as the first byte) resolves with `count` = 0.
  - Fixed mode: pulse `short`, go IDLE. `result` and `count` keep the partial field.
- RECV, `load` with any other byte:
  - If `count` < L, shift the byte in: `result` <= {result[(L-1)*B-1:0], data} and increment `count`.
  - Fixed mode: when the new `count` equals the length, pulse `resolve` with `term` = 0 and go IDLE.
  - Delimited mode with `count` == L: pulse `overflow`, go DISCARD. `result` holds the first L bytes.
- DISCARD: swallow bytes until a delimiter arrives, then go IDLE with no pulse.
- `resolve`, `overflow` and `short` are mutually exclusive.
- `result`, `count` and `term` hold stable from the pulse until the next `start` or `reset`.
- `reset` mid-field: immediate return to IDLE, no pulse.

## Timing
- All outputs are registered.
- A completing, overflowing or short `load` at cycle n gives its pulse at cycle n+1. `result`, `count` and `term` are valid in that same cycle.
- `busy` falls at n+1 together with the pulse.
- `start` at cycle n: `busy` = 1 at n+1, and the first `load` is accepted at n+1.
- Back-to-back: `start` may be asserted in the cycle the pulse is visible. `load` may be asserted every cycle.

## Structure
- Shared package `gpzda_pkg` holds:
  - the state enum;
  - the `term` encoding;
  - ASCII constants `ASCII_COMMA` and `ASCII_STAR`, used as defaults for the delimiter parameters.
- Sub-module `byte_shift_reg` (parameters B, L): clearable, load-enabled left-shift register. `field_receiver` owns the FSM, the counter, delimiter matching and the pulses.

## Test plan
- `length`=4, bytes `"2","0","2","1"` on consecutive cycles:
  - `resolve` one cycle after the 4th load;
  - `result[31:0]`=32'h32303231, `count`=4, `term`=0.
- `length`=0, bytes `"1","2",","`: `resolve` with `result[15:0]`=16'h3132, `count`=2, `term`=1, upper bytes 0.
- `length`=0, first byte `*`: `resolve` with `count`=0, `term`=2.
- `length`=0, L=10, 12 bytes `"A"` then `","`:
  - `overflow` pulse one cycle after the 11th load, `count`=10;
  - remaining bytes and the comma are swallowed, `busy` drops after the comma, no `resolve`.
- `length`=6, bytes `"1","2",","`: `short` pulse, `count`=2, `busy`=0 afterwards.
- Mid-field `start` and `reset`:
  - `start` asserted with a simultaneous `load` after 2 bytes: `count`=0 next cycle, and the field completes normally later;
  - `reset` mid-field: all outputs 0, no pulse.

Source files
------------

// File: rtl/gpzda_pkg.sv
// Shared types and constants for the GPZDA/NMEA sentence receive path.
package gpzda_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDiscard
  } state_e;

  typedef enum logic [1:0] {
    TermLength = 2'd0,
    TermDelimA = 2'd1,
    TermDelimB = 2'd2
  } term_e;

  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;

endpackage

// File: rtl/byte_shift_reg.sv
// Clearable, load-enabled left-shift register of L bytes; newest byte lands in the low byte.
module byte_shift_reg #(
  parameter int unsigned B = 8,
  parameter int unsigned L = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [B-1:0] data_i,
  output logic [L*B-1:0] q_o
);

  localparam int unsigned W = L * B;

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = (q_q << B) | W'(data_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/field_receiver.sv
// Collects a fixed-length or delimiter-terminated field of up to L bytes from a byte stream.
module field_receiver
  import gpzda_pkg::*;
#(
  parameter int unsigned   B       = 8,
  parameter int unsigned   L       = 10,
  parameter logic [B-1:0]  DELIM_A = ASCII_COMMA,
  parameter logic [B-1:0]  DELIM_B = ASCII_STAR,
  localparam int unsigned  CW      = $clog2(L + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [CW-1:0]  length,
  input  logic           load,
  input  logic [B-1:0]   data,
  output logic           busy,
  output logic           resolve,
  output logic           overflow,
  output logic           short,
  output logic [L*B-1:0] result,
  output logic [CW-1:0]  count,
  output logic [1:0]     term
);

  state_e        state_q, state_d;
  term_e         term_q, term_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic          resolve_q, resolve_d;
  logic          overflow_q, overflow_d;
  logic          short_q, short_d;
  logic          shift_clr, shift_en, is_delim;

  always_comb begin
    state_d    = state_q;
    term_d     = term_q;
    len_d      = len_q;
    count_d    = count_q;
    resolve_d  = 1'b0;
    overflow_d = 1'b0;
    short_d    = 1'b0;
    shift_clr  = 1'b0;
    shift_en   = 1'b0;
    is_delim   = (data == DELIM_A) || (data == DELIM_B);

    if (start) begin
      state_d   = StRecv;
      len_d     = (length > CW'(L)) ? CW'(L) : length;
      count_d   = '0;
      term_d    = TermLength;
      shift_clr = 1'b1;
    end else if (load) begin
      unique case (state_q)
        StRecv: begin
          if (is_delim) begin
            state_d = StIdle;
            // len_q == 0 marks delimited mode; a delimiter in fixed mode is a short field.
            if (len_q == '0) begin
              resolve_d = 1'b1;
              term_d    = (data == DELIM_A) ? TermDelimA : TermDelimB;
            end else begin
              short_d = 1'b1;
            end
          end else if (count_q < CW'(L)) begin
            shift_en = 1'b1;
            count_d  = count_q + CW'(1);
            if ((len_q != '0) && (count_d == len_q)) begin
              resolve_d = 1'b1;
              term_d    = TermLength;
              state_d   = StIdle;
            end
          end else begin
            overflow_d = 1'b1;
            state_d    = StDiscard;
          end
        end
        StDiscard: begin
          if (is_delim) state_d = StIdle;
        end
        default: ;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      term_q     <= TermLength;
      len_q      <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      resolve_q  <= 1'b0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      term_q     <= term_d;
      len_q      <= len_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      resolve_q  <= resolve_d;
      overflow_q <= overflow_d;
      short_q    <= short_d;
    end
  end

  byte_shift_reg #(
    .B(B),
    .L(L)
  ) u_shift (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (shift_clr),
    .en_i   (shift_en),
    .data_i (data),
    .q_o    (result)
  );

  assign busy     = busy_q;
  assign resolve  = resolve_q;
  assign overflow = overflow_q;
  assign short    = short_q;
  assign count    = count_q;
  assign term     = term_q;

endmodule
